// File: rtl/sync_fifo_param_if.sv
// Handshake bundle between a sync_fifo_param instance and its user.
// The master side is the producer/consumer logic; the slave side is the FIFO.
interface sync_fifo_param_if #(
  parameter int DATA_LINES = 8,
  parameter int ADDR_LINES = 4
);
  logic                  winc;
  logic [DATA_LINES-1:0] wdata;
  logic                  wfull;
  logic                  walmost_full;
  logic                  rinc;
  logic [DATA_LINES-1:0] rdata;
  logic                  rvalid;
  logic                  rempty;
  logic                  ralmost_empty;
  logic [ADDR_LINES:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output winc, wdata, rinc,
    input  wfull, walmost_full, rdata, rvalid, rempty, ralmost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc,
    output wfull, walmost_full, rdata, rvalid, rempty, ralmost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with registered read data, occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Pointers carry one extra wrap bit so full and empty are told apart by the
// plain difference wptr - rptr.
module sync_fifo_param #(
  parameter int DATA_LINES = 8,
  parameter int ADDR_LINES = 4,
  parameter int AF_MARGIN  = 2,
  parameter int AE_MARGIN  = 2
) (
  input  logic             clk,
  input  logic             rst,
  sync_fifo_param_if.slave f
);

  localparam int DEPTH = 1 << ADDR_LINES;
  localparam int PW    = ADDR_LINES + 1;

  // An illegal margin (>= DEPTH) pins walmost_full high; a threshold of 0
  // makes the >= comparison always true.
  localparam int AF_LEVEL = (AF_MARGIN >= DEPTH) ? 0 : DEPTH - AF_MARGIN;
  localparam int AE_LEVEL = (AE_MARGIN >  DEPTH) ? DEPTH : AE_MARGIN;

  localparam logic [PW-1:0] FULL_V = PW'(DEPTH);
  localparam logic [PW-1:0] AF_V   = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_V   = PW'(AE_LEVEL);

  logic [DATA_LINES-1:0] mem [DEPTH];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [PW-1:0]         occ;
  logic [DATA_LINES-1:0] rdata_q;
  logic                  rvalid_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  full;
  logic                  empty;
  logic                  we;
  logic                  re;

  // Flags decode registered pointers only, so no request reaches an output
  // combinationally.
  assign occ   = wptr - rptr;
  assign full  = (occ == FULL_V);
  assign empty = (occ == '0);
  assign we    = f.winc && !full;
  assign re    = f.rinc && !empty;

  // Storage write port; reset takes priority over an accepted write.
  // NOTE: the array is deliberately not reset -- entries are unreachable
  // until rewritten because reset equalises the pointers.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem[wptr[ADDR_LINES-1:0]] <= f.wdata;
    end
  end

  // Pointer, read-data and sticky error state with synchronous reset.
  // NOTE: every register here uses <= so all updates see pre-edge values,
  // which is what makes simultaneous read/write use the old flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (we) begin
        wptr <= wptr + PW'(1);
      end
      if (re) begin
        rptr    <= rptr + PW'(1);
        rdata_q <= mem[rptr[ADDR_LINES-1:0]];
      end
      rvalid_q <= re;
      if (f.winc && full) begin
        overflow_q <= 1'b1;
      end
      if (f.rinc && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign f.count         = occ;
  assign f.wfull         = full;
  assign f.rempty        = empty;
  assign f.walmost_full  = (occ >= AF_V);
  assign f.ralmost_empty = (occ <= AE_V);
  assign f.rdata         = rdata_q;
  assign f.rvalid        = rvalid_q;
  assign f.overflow      = overflow_q;
  assign f.underflow     = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DEPTH 8, margins 2).
// A queue-based model predicts every output after each rising edge.
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int AFM   = 2;
  localparam int AEM   = 2;

  logic clk;
  logic rst;

  sync_fifo_param_if #(.DATA_LINES(DW), .ADDR_LINES(AW)) fif ();

  sync_fifo_param #(
    .DATA_LINES(DW),
    .ADDR_LINES(AW),
    .AF_MARGIN (AFM),
    .AE_MARGIN (AEM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .f  (fif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] q [$];
  logic [DW-1:0] m_rdata;
  logic          m_rvalid;
  logic          m_ovf;
  logic          m_unf;

  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_rdata  = '0;
    m_rvalid = 1'b0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
  endtask

  // Apply one clock of stimulus, advance the model, compare every output.
  task automatic cycle(input logic w, input logic [DW-1:0] wd, input logic r, input logic rs);
    bit was_full, was_empty;
    rst       = rs;
    fif.winc  = w;
    fif.wdata = wd;
    fif.rinc  = r;
    @(posedge clk);
    if (rs) begin
      model_reset();
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      m_rvalid  = 1'b0;
      if (r && !was_empty) begin
        m_rdata  = q.pop_front();
        m_rvalid = 1'b1;
      end
      if (w && !was_full) q.push_back(wd);
      if (w && was_full)  m_ovf = 1'b1;
      if (r && was_empty) m_unf = 1'b1;
    end
    #1;
    check("count",         32'(fif.count),         32'(q.size()));
    check("wfull",         32'(fif.wfull),         32'(q.size() == DEPTH));
    check("rempty",        32'(fif.rempty),        32'(q.size() == 0));
    check("walmost_full",  32'(fif.walmost_full),  32'(q.size() >= DEPTH - AFM));
    check("ralmost_empty", 32'(fif.ralmost_empty), 32'(q.size() <= AEM));
    check("rvalid",        32'(fif.rvalid),        32'(m_rvalid));
    check("rdata",         32'(fif.rdata),         32'(m_rdata));
    check("overflow",      32'(fif.overflow),      32'(m_ovf));
    check("underflow",     32'(fif.underflow),     32'(m_unf));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    model_reset();
    rst       = 1'b1;
    fif.winc  = 1'b0;
    fif.wdata = '0;
    fif.rinc  = 1'b0;

    // Reset then idle
    cycle(0, 8'h00, 0, 1);
    cycle(0, 8'h00, 0, 1);
    cycle(0, 8'h00, 0, 0);

    // Fill with 0x10..0x17, then drain
    for (int i = 0; i < DEPTH; i++) cycle(1, 8'(8'h10 + i), 0, 0);
    check("full_after_fill", 32'(fif.wfull), 32'd1);
    for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 1, 0);
    check("last_drained", 32'(fif.rdata), 32'h17);
    cycle(0, 8'h00, 0, 0);

    // Full + simultaneous write/read: write rejected, overflow set
    for (int i = 0; i < DEPTH; i++) cycle(1, 8'(8'h20 + i), 0, 0);
    cycle(1, 8'hAA, 1, 0);
    check("ovf_count", 32'(fif.count), 32'd7);
    check("ovf_head",  32'(fif.rdata), 32'h20);
    for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 1, 0);

    // Empty + simultaneous write/read: read rejected, underflow set
    cycle(0, 8'h00, 0, 1);
    cycle(1, 8'h55, 1, 0);
    check("unf_count",  32'(fif.count),  32'd1);
    check("unf_rvalid", 32'(fif.rvalid), 32'd0);
    cycle(0, 8'h00, 1, 0);
    check("unf_read", 32'(fif.rdata), 32'h55);

    // Wrap: hold occupancy at 3 through 20 paired transfers
    cycle(0, 8'h00, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 8'(8'h30 + i), 0, 0);
    for (int i = 0; i < 20; i++) cycle(1, 8'($urandom), 1, 0);
    check("wrap_count", 32'(fif.count), 32'd3);

    // Reset with 5 queued and a concurrent write, then a blocked read
    cycle(0, 8'h00, 0, 1);
    for (int i = 0; i < 5; i++) cycle(1, 8'(8'h40 + i), 0, 0);
    cycle(1, 8'hEE, 0, 1);
    check("rst_count", 32'(fif.count), 32'd0);
    cycle(0, 8'h00, 1, 0);
    check("rst_underflow", 32'(fif.underflow), 32'd1);

    // Randomised traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 50),
            1'($urandom_range(0, 63) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
